pfu_ctrl_seq: RTL
=================

// Module: pfu_ctrl_seq
// PURPOSE
//  Registered, parametrised Pauli-frame-unit controller. It owns the PFU state
//  register, the PISR-memory and opcode-buffer occupancy counters, a queue of
//  pending RUN_ESM requests and a watchdog on error-decoder latency.
//  Sits between TCU/PIU/PSU (upstream) and the PISR memory, opbuf and Pauli-frame
//  RAM (downstream); replaces the combinational controller plus external state flop.
// PARAMETERS
//  OPCODE_BW     6    opcode width
//  RUN_ESM_OP    6'h3 opcode value meaning "run error-syndrome measurement"
//  PISR_DEPTH    16   PISR memory entries (power of 2 not required, >=2)
//  OPBUF_DEPTH   4    opcode-buffer entries (>=1)
//  PEND_BW       3    width of pending-ESM counter (saturates at 2^PEND_BW-1)
//  WAIT_TIMEOUT  255  max cycles in WAITING before declaring decoder timeout
// PORTS
//  clk             in   1          clock, rising edge
//  rst             in   1          async active-high reset
//  tcu_valid       in   1          tcu_opcode valid this cycle
//  tcu_opcode      in   OPCODE_BW  opcode from TCU
//  topsu_valid     in   1          PIU patch-info beat valid
//  piu_opcode      in   OPCODE_BW  opcode tagged on the PIU beat
//  last_pchinfo    in   1          PIU beat is last of its instruction group
//  pchwr_stall     in   1          downstream patch write stalled
//  pchinfo_rdlast  in   1          PISR read of last entry of the group this cycle
//  error_valid     in   1          decoder error word valid
//  pfflag          in   1          Pauli-frame flag accompanying error_valid
//  state           out  2          00 READY,01 UPDATING,10 WAITING,11 FAULT
//  pisrmem_push    out  1          write PISR memory (comb)
//  pisrmem_pop     out  1          read PISR memory (comb)
//  opbuf_push      out  1          write opbuf (comb)
//  opbuf_pop       out  1          read opbuf (comb)
//  sel_cwd_err     out  1          1=CWD path (UPDATING), 0=ERR path
//  pf_wren         out  1          Pauli-frame RAM write enable (comb)
//  pfu_valid       out  1          registered 1-cycle done pulse
//  pisr_cnt        out  clog2(PISR_DEPTH+1)   PISR occupancy
//  opbuf_cnt       out  clog2(OPBUF_DEPTH+1)  opbuf occupancy
//  esm_pending     out  PEND_BW    queued RUN_ESM requests
//  overflow        out  1          sticky: push attempted while full
//  timeout_err     out  1          sticky: WAITING exceeded WAIT_TIMEOUT
// BEHAVIOUR
//  Reset (async): state=READY; all counters, pfu_valid, overflow, timeout_err=0;
//   comb outputs evaluate from reset state (sel_cwd_err=0, pops=0).
//  esm_req = tcu_valid & tcu_opcode==RUN_ESM_OP; esm_pending +1 on esm_req,
//   -1 on WAITING->READY; both same cycle: unchanged; saturate at max, never <0.
//  pisrmem_push = topsu_valid & ~pchwr_stall & piu_opcode!=RUN_ESM_OP & pisr_cnt<PISR_DEPTH.
//  opbuf_push = pisrmem_push & last_pchinfo & opbuf_cnt<OPBUF_DEPTH; if opbuf full the
//   PISR push is also suppressed (group kept atomic). Suppressed push sets overflow.
//  pisrmem_pop = state==UPDATING & pisr_cnt!=0.
//  opbuf_pop = state==UPDATING & pchinfo_rdlast & pisrmem_pop.
//  Counters: push&pop same cycle -> unchanged; update on clk edge.
//  FSM (registered):
//   READY: esm_pending!=0 & opbuf_cnt!=0 -> UPDATING, else stay.
//   UPDATING: opbuf_pop -> WAITING; pchinfo_rdlast with pisr empty is ignored.
//   WAITING: error_valid -> READY; wait_cnt==WAIT_TIMEOUT -> FAULT, timeout_err=1.
//    wait_cnt cleared on entry, +1 each WAITING cycle without error_valid.
//   FAULT: held until rst; pushes still accepted, no pops, pf_wren=0.
//  sel_cwd_err = state==UPDATING. pf_wren = pisrmem_pop | (error_valid & state!=FAULT).
//  pfu_valid = 1 in the cycle after a WAITING->READY transition iff pfflag was 1
//   on the transition cycle; else 0.
//  error_valid in READY/UPDATING: writes PF RAM, no state effect.
//  Reset mid-UPDATING/WAITING: all state and counters drop immediately.
// TESTING
//  1 Reset then idle 10 cycles -> state=00, all counts 0, pfu_valid=0.
//  2 Push 3 beats (last on 3rd), esm_req -> READY->UPDATING 1 cycle after both,
//    3 pops, rdlast on 3rd -> WAITING, opbuf_cnt=0, pisr_cnt=0.
//  3 In WAITING error_valid=1,pfflag=1 -> READY next edge, pfu_valid=1 one cycle,
//    esm_pending 1->0; repeat with pfflag=0 -> pfu_valid stays 0.
//  4 PISR_DEPTH+2 push attempts with no pop -> pisr_cnt=16, overflow=1, push low
//    on last two; push&pop same cycle in UPDATING -> count constant.
//  5 WAITING with no error_valid for 256 cycles -> state=11, timeout_err=1; rst
//    asserted async -> state=00 before next edge.
//  6 8 esm_req with PEND_BW=3 -> esm_pending saturates at 7.

Source files
------------

// File: rtl/pfu_ctrl_seq.sv
// Pauli-frame-unit controller: owns the PFU state, PISR/opbuf occupancy, pending
// RUN_ESM requests and a decoder-latency watchdog, all registered.
module pfu_ctrl_seq #(
    parameter int OPCODE_BW                  = 6,
    parameter logic [OPCODE_BW-1:0] RUN_ESM_OP = OPCODE_BW'(3),
    parameter int PISR_DEPTH                 = 16,
    parameter int OPBUF_DEPTH                = 4,
    parameter int PEND_BW                    = 3,
    parameter int WAIT_TIMEOUT               = 255,
    localparam int PISR_CW                   = $clog2(PISR_DEPTH + 1),
    localparam int OPBUF_CW                  = $clog2(OPBUF_DEPTH + 1),
    localparam int WAIT_CW                   = $clog2(WAIT_TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tcu_valid,
    input  logic [OPCODE_BW-1:0] tcu_opcode,
    input  logic                 topsu_valid,
    input  logic [OPCODE_BW-1:0] piu_opcode,
    input  logic                 last_pchinfo,
    input  logic                 pchwr_stall,
    input  logic                 pchinfo_rdlast,
    input  logic                 error_valid,
    input  logic                 pfflag,
    output logic [1:0]           state,
    output logic                 pisrmem_push,
    output logic                 pisrmem_pop,
    output logic                 opbuf_push,
    output logic                 opbuf_pop,
    output logic                 sel_cwd_err,
    output logic                 pf_wren,
    output logic                 pfu_valid,
    output logic [PISR_CW-1:0]   pisr_cnt,
    output logic [OPBUF_CW-1:0]  opbuf_cnt,
    output logic [PEND_BW-1:0]   esm_pending,
    output logic                 overflow,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_READY    = 2'b00,
        ST_UPDATING = 2'b01,
        ST_WAITING  = 2'b10,
        ST_FAULT    = 2'b11
    } state_t;

    localparam logic [PEND_BW-1:0]  PEND_MAX  = {PEND_BW{1'b1}};
    localparam logic [PISR_CW-1:0]  PISR_FULL = PISR_CW'(PISR_DEPTH);
    localparam logic [OPBUF_CW-1:0] OPBUF_FULL = OPBUF_CW'(OPBUF_DEPTH);
    localparam logic [WAIT_CW-1:0]  WAIT_LIMIT = WAIT_CW'(WAIT_TIMEOUT);

    state_t               state_q, state_d;
    logic [PISR_CW-1:0]   pisr_cnt_q, pisr_cnt_d;
    logic [OPBUF_CW-1:0]  opbuf_cnt_q, opbuf_cnt_d;
    logic [PEND_BW-1:0]   esm_pending_q, esm_pending_d;
    logic [WAIT_CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic                 pfu_valid_q, pfu_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 timeout_err_q, timeout_err_d;

    logic esm_req;
    logic push_req;
    logic pisr_push;
    logic pisr_pop;
    logic ob_push;
    logic ob_pop;
    logic leave_wait;

    // Push/pop are single-cycle strobes: the memory acts on the edge that ends the
    // cycle they are high, with no ready back-channel; occupancy and pchwr_stall
    // are the only throttles, so a strobe is only raised when it can complete.
    always_comb begin
        esm_req    = tcu_valid & (tcu_opcode == RUN_ESM_OP);
        push_req   = topsu_valid & ~pchwr_stall & (piu_opcode != RUN_ESM_OP);
        // A last beat with a full opbuf is dropped whole so the group stays atomic.
        pisr_push  = push_req & (pisr_cnt_q < PISR_FULL)
                   & ~(last_pchinfo & (opbuf_cnt_q >= OPBUF_FULL));
        ob_push    = pisr_push & last_pchinfo;
        pisr_pop   = (state_q == ST_UPDATING) & (pisr_cnt_q != '0);
        ob_pop     = pisr_pop & pchinfo_rdlast;
        leave_wait = (state_q == ST_WAITING) & error_valid;
    end

    always_comb begin
        state_d       = state_q;
        pisr_cnt_d    = pisr_cnt_q;
        opbuf_cnt_d   = opbuf_cnt_q;
        esm_pending_d = esm_pending_q;
        wait_cnt_d    = wait_cnt_q;
        pfu_valid_d   = leave_wait & pfflag;
        overflow_d    = overflow_q | (push_req & ~pisr_push);
        timeout_err_d = timeout_err_q;

        if (pisr_push && !pisr_pop) begin
            pisr_cnt_d = pisr_cnt_q + 1'b1;
        end else if (pisr_pop && !pisr_push) begin
            pisr_cnt_d = pisr_cnt_q - 1'b1;
        end

        if (ob_push && !ob_pop) begin
            opbuf_cnt_d = opbuf_cnt_q + 1'b1;
        end else if (ob_pop && !ob_push && opbuf_cnt_q != '0) begin
            opbuf_cnt_d = opbuf_cnt_q - 1'b1;
        end

        if (esm_req && !leave_wait && esm_pending_q != PEND_MAX) begin
            esm_pending_d = esm_pending_q + 1'b1;
        end else if (leave_wait && !esm_req && esm_pending_q != '0) begin
            esm_pending_d = esm_pending_q - 1'b1;
        end

        case (state_q)
            ST_READY: begin
                if (esm_pending_q != '0 && opbuf_cnt_q != '0) begin
                    state_d = ST_UPDATING;
                end
            end
            ST_UPDATING: begin
                if (ob_pop) begin
                    state_d    = ST_WAITING;
                    wait_cnt_d = '0;
                end
            end
            ST_WAITING: begin
                if (error_valid) begin
                    state_d = ST_READY;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d       = ST_FAULT;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_READY;
            pisr_cnt_q    <= '0;
            opbuf_cnt_q   <= '0;
            esm_pending_q <= '0;
            wait_cnt_q    <= '0;
            pfu_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pisr_cnt_q    <= pisr_cnt_d;
            opbuf_cnt_q   <= opbuf_cnt_d;
            esm_pending_q <= esm_pending_d;
            wait_cnt_q    <= wait_cnt_d;
            pfu_valid_q   <= pfu_valid_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign state        = state_q;
    assign pisrmem_push = pisr_push;
    assign pisrmem_pop  = pisr_pop;
    assign opbuf_push   = ob_push;
    assign opbuf_pop    = ob_pop;
    assign sel_cwd_err  = (state_q == ST_UPDATING);
    assign pf_wren      = pisr_pop | (error_valid & (state_q != ST_FAULT));
    assign pfu_valid    = pfu_valid_q;
    assign pisr_cnt     = pisr_cnt_q;
    assign opbuf_cnt    = opbuf_cnt_q;
    assign esm_pending  = esm_pending_q;
    assign overflow     = overflow_q;
    assign timeout_err  = timeout_err_q;

endmodule
